// File: rtl/imm_narrower.sv
// Narrows a 32-bit value into the 16/22/12/18-bit immediate field picked by selectSize,
// queues the result in a small FIFO and keeps overflow statistics for non-fitting values.
module imm_narrower #(
  parameter int DEPTH    = 2,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       selectSize,
  input  logic [31:0]      value32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [21:0]      out_field,
  output logic [1:0]       out_size,
  output logic             out_fits,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sticky
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mask;
  logic          fits;
  logic [21:0]   field;
  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [24:0]   head;

  // Field mask doubles as the saturation value: bits above the field stay zero.
  always_comb begin
    mask = 32'h0000_FFFF;
    case (selectSize)
      2'b00: mask = 32'h0000_FFFF;
      2'b01: mask = 32'h003F_FFFF;
      2'b10: mask = 32'h0000_0FFF;
      2'b11: mask = 32'h0003_FFFF;
      default: mask = 32'h0000_FFFF;
    endcase
    fits  = (value32 & ~mask) == 32'h0;
    field = ((SATURATE != 0) && !fits) ? mask[21:0] : (value32[21:0] & mask[21:0]);
  end

  assign in_ready  = count < DEPTH_C;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Head is masked while empty so stale entries never show after draining.
  assign out_field = out_valid ? head[21:0]  : 22'h0;
  assign out_fits  = out_valid ? head[22]    : 1'b0;
  assign out_size  = out_valid ? head[24:23] : 2'b00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {selectSize, fits, field};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear in the same cycle as a non-fitting accept wins over counting it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr_stats) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (push && !fits) begin
      if (ovf_count != {CNT_W{1'b1}}) ovf_count <= ovf_count + CNT_W'(1);
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_narrower.sv
// Drives a truncating (8-bit counter) and a saturating (2-bit counter) narrower with the
// same stimulus and scores both against a queue of expected FIFO entries.
module tb_imm_narrower;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] value;
    logic [21:0] f_trunc;
    logic [21:0] f_sat;
    logic        fits;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  selectSize = 2'b00;
  logic [31:0] value32 = 32'h0;
  logic        out_ready = 1'b0;
  logic        clr_stats = 1'b0;

  logic        in_ready_a, out_valid_a, out_fits_a, ovf_sticky_a;
  logic [21:0] out_field_a;
  logic [1:0]  out_size_a;
  logic [7:0]  ovf_count_a;
  logic        in_ready_b, out_valid_b, out_fits_b, ovf_sticky_b;
  logic [21:0] out_field_b;
  logic [1:0]  out_size_b;
  logic [1:0]  ovf_count_b;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t sb[$];
  vec_t pending;
  vec_t tbl[8];
  logic last_accept;
  int   cnt_a = 0, cnt_b = 0;
  logic sticky = 1'b0;

  always #5 clock = ~clock;

  imm_narrower #(.DEPTH(2), .SATURATE(0), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .selectSize(selectSize), .value32(value32), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_field(out_field_a), .out_size(out_size_a),
    .out_fits(out_fits_a), .clr_stats(clr_stats), .ovf_count(ovf_count_a),
    .ovf_sticky(ovf_sticky_a)
  );

  imm_narrower #(.DEPTH(2), .SATURATE(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .selectSize(selectSize), .value32(value32), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_field(out_field_b), .out_size(out_size_b),
    .out_fits(out_fits_b), .clr_stats(clr_stats), .ovf_count(ovf_count_b),
    .ovf_sticky(ovf_sticky_b)
  );

  // Reference narrowing built from shifts rather than a mask table.
  function automatic vec_t model(input logic [1:0] sel, input logic [31:0] v);
    vec_t r;
    int w;
    logic [31:0] m;
    case (sel)
      2'd0: w = 16;
      2'd1: w = 22;
      2'd2: w = 12;
      default: w = 18;
    endcase
    m = (32'h1 << w) - 32'h1;
    r.sel = sel;
    r.value = v;
    r.fits = (v >> w) == 32'h0;
    r.f_trunc = 22'(v & m);
    r.f_sat = r.fits ? 22'(v & m) : 22'(m);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model at the edge.
  task automatic cycle();
    logic acc, pp;
    vec_t e;
    checkOutput("in_ready_a", in_ready_a, sb.size() < 2);
    checkOutput("in_ready_b", in_ready_b, sb.size() < 2);
    checkOutput("out_valid_a", out_valid_a, sb.size() != 0);
    checkOutput("out_valid_b", out_valid_b, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb[0];
      checkOutput("field_trunc", out_field_a, e.f_trunc);
      checkOutput("field_sat", out_field_b, e.f_sat);
      checkOutput("size_a", out_size_a, e.sel);
      checkOutput("size_b", out_size_b, e.sel);
      checkOutput("fits_a", out_fits_a, e.fits);
      checkOutput("fits_b", out_fits_b, e.fits);
    end
    checkOutput("ovf_count_a", ovf_count_a, cnt_a);
    checkOutput("ovf_count_b", ovf_count_b, cnt_b);
    checkOutput("ovf_sticky_a", ovf_sticky_a, sticky);
    checkOutput("ovf_sticky_b", ovf_sticky_b, sticky);
    acc = in_valid && (sb.size() < 2);
    pp  = (sb.size() != 0) && out_ready;
    @(posedge clock);
    if (pp) void'(sb.pop_front());
    if (acc) sb.push_back(pending);
    if (clr_stats) begin
      cnt_a = 0;
      cnt_b = 0;
      sticky = 1'b0;
    end else if (acc && !pending.fits) begin
      if (cnt_a < 255) cnt_a++;
      if (cnt_b < 3) cnt_b++;
      sticky = 1'b1;
    end
    last_accept = acc;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input vec_t v, input logic clr);
    int n;
    selectSize = v.sel;
    value32 = v.value;
    in_valid = 1'b1;
    clr_stats = clr;
    pending = v;
    n = 0;
    last_accept = 1'b0;
    while (!last_accept && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("accept_timeout", last_accept, 1'b1);
    in_valid = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'h0000_BEEF, 22'h00BEEF, 22'h00BEEF, 1'b1};
    tbl[1] = '{2'd1, 32'h003F_FFFF, 22'h3FFFFF, 22'h3FFFFF, 1'b1};
    tbl[2] = '{2'd1, 32'h0040_0000, 22'h000000, 22'h3FFFFF, 1'b0};
    tbl[3] = '{2'd2, 32'h0000_1000, 22'h000000, 22'h000FFF, 1'b0};
    tbl[4] = '{2'd3, 32'h0003_FFFF, 22'h03FFFF, 22'h03FFFF, 1'b1};
    tbl[5] = '{2'd3, 32'hFFFF_FFFF, 22'h03FFFF, 22'h03FFFF, 1'b0};
    tbl[6] = '{2'd2, 32'h0000_0ABC, 22'h000ABC, 22'h000ABC, 1'b1};
    tbl[7] = '{2'd0, 32'h1234_5678, 22'h005678, 22'h00FFFF, 1'b0};

    // Reset values while held in reset
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_out_valid", out_valid_a, 1'b0);
    checkOutput("rst_field", out_field_a, 22'h0);
    checkOutput("rst_size", out_size_a, 2'b00);
    checkOutput("rst_fits", out_fits_a, 1'b0);
    checkOutput("rst_ovf", ovf_count_a, 8'h0);
    checkOutput("rst_sticky", ovf_sticky_b, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Table vectors with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i], 1'b0);
      if (i == 3) checkOutput("ovf_after_bounds", ovf_count_a, 8'd2);
    end
    for (int i = 0; i < 3; i++) cycle();

    // Backpressure: third word must wait for the first pop
    out_ready = 1'b0;
    applyStimulus(model(2'd0, 32'h0000_1111), 1'b0);
    applyStimulus(model(2'd1, 32'h0000_2222), 1'b0);
    pending = model(2'd2, 32'h0000_0333);
    selectSize = 2'd2;
    value32 = 32'h0000_0333;
    in_valid = 1'b1;
    cycle();
    checkOutput("bp_held1", last_accept, 1'b0);
    cycle();
    checkOutput("bp_held2", last_accept, 1'b0);
    out_ready = 1'b1;
    cycle();
    checkOutput("bp_full_pop", last_accept, 1'b0);
    cycle();
    checkOutput("bp_accept_after_pop", last_accept, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Streaming: one word per cycle
    for (int i = 0; i < 8; i++) applyStimulus(model(2'd3, 32'(i)), 1'b0);
    for (int i = 0; i < 2; i++) cycle();

    // Counter saturation, then clear racing a non-fitting accept
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(model(2'd2, 32'h0000_F000 + 32'(i)), 1'b0);
    checkOutput("sat_count_b", ovf_count_b, 2'd3);
    checkOutput("count_a_five", ovf_count_a, 8'd5);
    checkOutput("sat_sticky", ovf_sticky_b, 1'b1);
    applyStimulus(model(2'd2, 32'h0000_F0F0), 1'b1);
    checkOutput("clr_count_a", ovf_count_a, 8'd0);
    checkOutput("clr_count_b", ovf_count_b, 2'd0);
    checkOutput("clr_sticky", ovf_sticky_a, 1'b0);
    for (int i = 0; i < 2; i++) cycle();

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    applyStimulus(model(2'd0, 32'h0001_0000), 1'b0);
    applyStimulus(model(2'd0, 32'h0002_0000), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_out_valid_a", out_valid_a, 1'b0);
    checkOutput("async_out_valid_b", out_valid_b, 1'b0);
    checkOutput("async_ovf", ovf_count_a, 8'd0);
    sb.delete();
    cnt_a = 0;
    cnt_b = 0;
    sticky = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
